// File: rtl/mio_ram_arbiter_if.sv
// Bus bundle between the two RAM masters, the arbiter and the shared RAM.
// Ports: m0_*/m1_* master request/ack channels, ram_* RAM port, busy/gnt_id status.
interface mio_ram_arbiter_if #(
    parameter int AW = 6,
    parameter int DW = 32
);
    logic          m0_req;
    logic          m0_we;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_ack;
    logic [DW-1:0] m0_rdata;

    logic          m1_req;
    logic          m1_we;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_ack;
    logic [DW-1:0] m1_rdata;

    logic          ram_we;
    logic [AW-1:0] ram_a;
    logic [DW-1:0] ram_d;
    logic [DW-1:0] ram_q;

    logic          busy;
    logic          gnt_id;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_ack, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata,
        output m1_ack, m1_rdata,
        output ram_we, ram_a, ram_d,
        input  ram_q,
        output busy, gnt_id
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_ack, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata,
        input  m1_ack, m1_rdata,
        input  ram_we, ram_a, ram_d,
        output ram_q,
        input  busy, gnt_id
    );
endinterface

// File: rtl/mio_ram_arbiter.sv
// Round-robin two-master arbiter/sequencer for the shared single-port data RAM.
// Ports: clk, clrn (async active-low), bus (slave modport: masters, RAM port, status).
module mio_ram_arbiter #(
    parameter int AW     = 6,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic                 clk,
    input  logic                 clrn,
    mio_ram_arbiter_if.slave     bus
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        ACK
    } state_t;

    localparam logic [1:0] LAT = 2'(RD_LAT);

    state_t     state_q;
    logic [1:0] cnt_q;
    logic       rr_last_q;

    logic       any_req;
    logic       win;

    // On a tie the master that was not served last wins.
    always_comb begin
        any_req = bus.m0_req | bus.m1_req;
        win     = 1'b0;
        unique case (1'b1)
            bus.m0_req & bus.m1_req:  win = ~rr_last_q;
            bus.m1_req & ~bus.m0_req: win = 1'b1;
            default:                  win = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rr_last_q    <= 1'b1;
            bus.m0_ack   <= 1'b0;
            bus.m1_ack   <= 1'b0;
            bus.m0_rdata <= '0;
            bus.m1_rdata <= '0;
            bus.ram_we   <= 1'b0;
            bus.ram_a    <= '0;
            bus.ram_d    <= '0;
            bus.busy     <= 1'b0;
            bus.gnt_id   <= 1'b0;
        end else begin
            bus.m0_ack <= 1'b0;
            bus.m1_ack <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (any_req) begin
                        bus.gnt_id <= win;
                        bus.ram_we <= win ? bus.m1_we    : bus.m0_we;
                        bus.ram_a  <= win ? bus.m1_addr  : bus.m0_addr;
                        bus.ram_d  <= win ? bus.m1_wdata : bus.m0_wdata;
                        cnt_q      <= LAT;
                        bus.busy   <= 1'b1;
                        state_q    <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Write strobe lives only in the first access cycle.
                    bus.ram_we <= 1'b0;
                    cnt_q      <= cnt_q - 2'd1;
                    if (cnt_q == 2'd1) begin
                        if (bus.gnt_id) begin
                            bus.m1_rdata <= bus.ram_q;
                            bus.m1_ack   <= 1'b1;
                        end else begin
                            bus.m0_rdata <= bus.ram_q;
                            bus.m0_ack   <= 1'b1;
                        end
                        state_q <= ACK;
                    end
                end
                ACK: begin
                    rr_last_q <= bus.gnt_id;
                    bus.busy  <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
